fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the MIPS core, directly upstream of the control decoder.
//  Holds the PC and issues one word request at a time to instruction memory.
//  Registers the returned word into an IF/ID slot that feeds the decoder (instruction31_26, instruction5_0).
//  Applies Branch/Jump redirects resolved downstream, discarding stale in-flight words.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_WORD  32'h0000_0000  word presented in the IF/ID slot when it is empty
// PORTS
//  clk               in   1   single clock, all state on rising edge
//  rst               in   1   synchronous, active-high reset
//  imem_req_valid    out  1   request valid toward instruction memory
//  imem_req_ready    in   1   memory accepts request this cycle
//  imem_addr         out  32  word address requested (always pc, low 2 bits 0)
//  imem_rsp_valid    in   1   response word valid (no backpressure; always accepted)
//  imem_rsp_data     in   32  response word
//  id_valid          out  1   IF/ID slot holds a live instruction
//  id_ready          in   1   decode consumes the slot this cycle
//  id_instr          out  32  instruction word (NOP_WORD when id_valid=0)
//  instruction31_26  out  6   id_instr[31:26], opcode to decoder
//  instruction5_0    out  6   id_instr[5:0], funct to decoder
//  id_pc_plus4       out  32  PC+4 of the instruction in the slot
//  ex_pc_plus4       in   32  PC+4 of the resolving branch/jump instruction
//  branch            in   1   Branch from control, resolved this cycle
//  alu_zero          in   1   ALU zero flag for the resolving BEQ
//  branch_imm        in   16  BEQ immediate (instr[15:0])
//  jump              in   1   Jump from control, resolved this cycle
//  jump_index        in   26  J target field (instr[25:0])
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_FETCH, id_valid=0, id_instr=NOP_WORD, id_pc_plus4=0, buffer empty,
//    imem_req_valid=0 during the reset cycle; first request issued the cycle after rst deasserts.
//  Redirect: redirect = jump | (branch & alu_zero). jump has priority if both asserted.
//    jump target   = {ex_pc_plus4[31:28], jump_index, 2'b00}
//    branch target = ex_pc_plus4 + ({{14{branch_imm[15]}}, branch_imm, 2'b00}), modulo 2^32.
//  Skid buffer: one entry, holds a live response that arrives while the slot is full and not consumed.
//  FSM (single outstanding request):
//    S_FETCH: imem_req_valid=1, imem_addr=pc. On req_ready: pc<=pc+4 (wraps modulo 2^32), go to S_WAIT.
//    S_WAIT: on rsp_valid, write to the slot if the slot is empty or id_ready=1, then go to S_FETCH.
//      Otherwise write to the skid buffer and go to S_HOLD.
//    S_HOLD: no request. When id_ready=1, the buffer moves to the slot; go to S_FETCH.
//    S_KILL: no request. On rsp_valid, discard the word; go to S_FETCH.
//  Redirect in any state, same edge: pc<=target, id_valid<=0, buffer cleared.
//    From S_WAIT with no rsp_valid that cycle -> S_KILL.
//    From S_WAIT with rsp_valid that cycle -> S_FETCH; the word is discarded.
//    From S_FETCH with req_ready -> S_KILL; the request is still issued at the old pc.
//    Otherwise -> S_FETCH.
//  Redirect in S_KILL: pc is updated; state stays S_KILL.
//  Redirect wins over slot load, buffer load and pc+4 in the same cycle.
//  id_ready with id_valid=0 is ignored. Slot contents are stable while id_valid=1 and id_ready=0.
//  Throughput: one instruction per 2 cycles with zero-latency memory (no prefetch beyond one).
//  Reset asserted mid-request: state returns to the reset values.
//    A response arriving after reset is ignored unless the state is S_WAIT.
// STRUCTURE
//  fetch_pkg: fetch_state_e {S_FETCH,S_WAIT,S_HOLD,S_KILL}, NOP_WORD, RESET_PC default, PC_STEP=4.
//  Sub-module next_pc_calc: combinational; inputs pc, ex_pc_plus4, branch_imm, jump_index, branch, alu_zero, jump.
//    Outputs redirect, redirect_pc and pc_plus4.
//  fetch_unit: FSM, PC register, IF/ID slot, skid buffer.
// TESTING
//  Reset, then 3 fetches with 1-cycle memory from a stream of {ADD,SUB,OR}:
//    addr 0,4,8; slot shows the words in order; id_pc_plus4 = 4,8,12.
//  Hold id_ready=0 for 5 cycles after slot fill:
//    next word goes to the buffer, state S_HOLD, no imem_req_valid.
//    Release -> no word lost or duplicated.
//  BEQ taken: ex_pc_plus4=0x20, imm=0xFFFE, branch=1, alu_zero=1 -> next imem_addr=0x18, slot flushed.
//    Same stimulus with alu_zero=0 -> no redirect.
//  Jump: ex_pc_plus4=0x8000_0010, jump_index=0x0000040 -> next imem_addr=0x8000_0100.
//    Jump and taken branch in the same cycle -> jump target used.
//  Redirect during S_WAIT with 3-cycle memory latency -> stale word discarded (never id_valid).
//    Next request goes to the target after the stale response returns.
//  RESET_PC=32'hFFFF_FFFC: second request addr=0 (wrap).
//    rst asserted in S_WAIT -> pc=RESET_PC, id_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and constants shared by the instruction fetch stage
package fetch_pkg;
    typedef logic [1:0] fetch_state_e;
    localparam fetch_state_e S_FETCH = 2'd0;
    localparam fetch_state_e S_WAIT = 2'd1;
    localparam fetch_state_e S_HOLD = 2'd2;
    localparam fetch_state_e S_KILL = 2'd3;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: sequential PC increment and branch/jump redirect target selection
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ex_pc_plus4,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] pc_plus4
);
    always_comb begin
        pc_plus4 = pc + PC_STEP;
        redirect = jump | (branch & alu_zero);
        redirect_pc = jump ? {ex_pc_plus4[31:28], jump_index, 2'b00}
                           : ex_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with IF/ID slot, skid buffer and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [5:0]  instruction31_26,
    output logic [5:0]  instruction5_0,
    output logic [31:0] id_pc_plus4,
    input  logic [31:0] ex_pc_plus4,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index
);
    fetch_state_e state;
    logic [31:0] pc, pc_plus4, redirect_pc, slot_instr, buf_instr;
    logic redirect, slot_free;

    next_pc_calc u_next_pc (
        .pc(pc),
        .ex_pc_plus4(ex_pc_plus4),
        .branch_imm(branch_imm),
        .jump_index(jump_index),
        .branch(branch),
        .alu_zero(alu_zero),
        .jump(jump),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .pc_plus4(pc_plus4)
    );

    always_comb begin
        slot_free = !id_valid || id_ready;
        imem_req_valid = !rst && state == S_FETCH;
        imem_addr = {pc[31:2], 2'b00};
        id_instr = id_valid ? slot_instr : NOP_WORD;
        instruction31_26 = id_instr[31:26];
        instruction5_0 = id_instr[5:0];
    end

    // pc already points past the outstanding word, so it doubles as that word's PC+4
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc <= RESET_PC;
            id_valid <= 1'b0;
            slot_instr <= NOP_WORD;
            id_pc_plus4 <= 32'h0;
            buf_instr <= NOP_WORD;
        end else if (redirect) begin
            pc <= redirect_pc;
            id_valid <= 1'b0;
            state <= ((state == S_WAIT || state == S_KILL) && !imem_rsp_valid) ||
                     (state == S_FETCH && imem_req_ready) ? S_KILL : S_FETCH;
        end else begin
            if (id_valid && id_ready) id_valid <= 1'b0;
            case (state)
                S_FETCH: if (imem_req_ready) begin
                    pc <= pc_plus4;
                    state <= S_WAIT;
                end
                S_WAIT: if (imem_rsp_valid) begin
                    if (slot_free) begin
                        id_valid <= 1'b1;
                        slot_instr <= imem_rsp_data;
                        id_pc_plus4 <= pc;
                        state <= S_FETCH;
                    end else begin
                        buf_instr <= imem_rsp_data;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: if (id_ready) begin
                    id_valid <= 1'b1;
                    slot_instr <= buf_instr;
                    id_pc_plus4 <= pc;
                    state <= S_FETCH;
                end
                default: if (imem_rsp_valid) state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, redirects, latency and PC wrap
module tb_fetch_unit;
    localparam logic [31:0] ADD = 32'h0022_1820;
    localparam logic [31:0] SUB = 32'h0022_1822;
    localparam logic [31:0] OR_ = 32'h0022_1825;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid, id_valid, id_ready;
    logic [31:0] imem_addr, imem_rsp_data, id_instr, id_pc_plus4, ex_pc_plus4;
    logic [5:0] op, fn;
    logic branch, alu_zero, jump;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;

    logic w_req_valid, w_req_ready, w_rsp_valid, w_id_valid, w_id_ready;
    logic [31:0] w_addr, w_rsp_data, w_id_instr, w_pp4;
    logic [5:0] w_op, w_fn;

    int n_chk = 0, n_pass = 0, lat = 1, cnt = 0;
    logic pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] exp_w [3] = '{ADD, SUB, OR_};
    logic [5:0] exp_fn [3] = '{6'h20, 6'h22, 6'h25};

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .instruction31_26(op), .instruction5_0(fn), .id_pc_plus4(id_pc_plus4),
        .ex_pc_plus4(ex_pc_plus4), .branch(branch), .alu_zero(alu_zero), .branch_imm(branch_imm),
        .jump(jump), .jump_index(jump_index)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .id_valid(w_id_valid), .id_ready(w_id_ready), .id_instr(w_id_instr),
        .instruction31_26(w_op), .instruction5_0(w_fn), .id_pc_plus4(w_pp4),
        .ex_pc_plus4(32'h0), .branch(1'b0), .alu_zero(1'b0), .branch_imm(16'h0),
        .jump(1'b0), .jump_index(26'h0)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? ADD : a == 32'h4 ? SUB : a == 32'h8 ? OR_ : 32'h2000_0000 | a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // memory model: answers an accepted request lat cycles after acceptance
    task automatic cyc();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(paddr);
                pend = 1'b0;
            end else cnt--;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend = 1'b1;
            paddr = imem_addr;
            cnt = lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b1;
        ex_pc_plus4 = 32'h0; branch = 1'b0; alu_zero = 1'b0; branch_imm = 16'h0;
        jump = 1'b0; jump_index = 26'h0;
        w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0; w_id_ready = 1'b0;
        cyc();
        cyc();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_pc_plus4", id_pc_plus4, 32'h0);
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", imem_addr, 32'(4 * i));
            cyc();
            cyc();
            check("seq_valid", id_valid, 1);
            check("seq_instr", id_instr, exp_w[i]);
            check("seq_opcode", op, 6'h0);
            check("seq_funct", fn, exp_fn[i]);
            check("seq_pc_plus4", id_pc_plus4, 32'(4 * i + 4));
        end
        id_ready = 1'b0;
        cyc();
        cyc();
        check("hold_req_valid", imem_req_valid, 0);
        check("hold_instr", id_instr, OR_);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("hold_stable_req", imem_req_valid, 0);
            check("hold_stable_instr", id_instr, OR_);
            check("hold_stable_valid", id_valid, 1);
        end
        id_ready = 1'b1;
        cyc();
        check("release_instr", id_instr, 32'h2000_000C);
        check("release_pc_plus4", id_pc_plus4, 32'h10);
        check("release_addr", imem_addr, 32'h10);
        check("release_req_valid", imem_req_valid, 1);
        cyc();
        cyc();
        check("after_release_instr", id_instr, 32'h2000_0010);
        check("after_release_pc4", id_pc_plus4, 32'h14);
        ex_pc_plus4 = 32'h20; branch_imm = 16'hFFFE; branch = 1'b1; alu_zero = 1'b1;
        cyc();
        branch = 1'b0; alu_zero = 1'b0;
        check("beq_flush", id_valid, 0);
        check("beq_kill_req", imem_req_valid, 0);
        check("beq_target", imem_addr, 32'h18);
        cyc();
        check("beq_refetch_req", imem_req_valid, 1);
        check("beq_refetch_addr", imem_addr, 32'h18);
        check("beq_stale_dropped", id_valid, 0);
        cyc();
        cyc();
        check("beq_target_instr", id_instr, 32'h2000_0018);
        check("beq_target_pc4", id_pc_plus4, 32'h1C);
        branch = 1'b1; alu_zero = 1'b0;
        cyc();
        branch = 1'b0;
        check("bne_no_redirect", imem_addr, 32'h20);
        cyc();
        check("bne_instr", id_instr, 32'h2000_001C);
        imem_req_ready = 1'b0;
        ex_pc_plus4 = 32'h8000_0010; jump_index = 26'h40; jump = 1'b1;
        cyc();
        jump = 1'b0;
        check("jump_target", imem_addr, 32'h8000_0100);
        check("jump_req_valid", imem_req_valid, 1);
        check("jump_flush", id_valid, 0);
        jump_index = 26'h80; jump = 1'b1; branch = 1'b1; alu_zero = 1'b1; branch_imm = 16'hFFFE;
        cyc();
        jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        check("jump_priority", imem_addr, 32'h8000_0200);
        imem_req_ready = 1'b1;
        lat = 3;
        cyc();
        check("lat3_wait", imem_req_valid, 0);
        ex_pc_plus4 = 32'h10; jump_index = 26'h10; jump = 1'b1;
        cyc();
        jump = 1'b0;
        check("kill_req", imem_req_valid, 0);
        check("kill_target", imem_addr, 32'h40);
        cyc();
        check("kill_wait_req", imem_req_valid, 0);
        check("kill_wait_valid", id_valid, 0);
        cyc();
        check("kill_done_req", imem_req_valid, 1);
        check("kill_done_addr", imem_addr, 32'h40);
        check("kill_stale_never", id_valid, 0);
        cyc();
        cyc();
        check("lat3_pending1", id_valid, 0);
        cyc();
        check("lat3_pending2", id_valid, 0);
        cyc();
        check("lat3_instr", id_instr, 32'h2000_0040);
        check("lat3_pc4", id_pc_plus4, 32'h44);
        lat = 1;
        check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        check("wrap_first_req", w_req_valid, 1);
        w_req_ready = 1'b1;
        cyc();
        w_req_ready = 1'b0;
        check("wrap_pc", w_addr, 32'h0);
        check("wrap_wait_req", w_req_valid, 0);
        w_rsp_valid = 1'b1; w_rsp_data = 32'h1234_5678;
        cyc();
        w_rsp_valid = 1'b0;
        check("wrap_instr", w_id_instr, 32'h1234_5678);
        check("wrap_pc4", w_pp4, 32'h0);
        check("wrap_second_addr", w_addr, 32'h0);
        check("wrap_second_req", w_req_valid, 1);
        w_req_ready = 1'b1;
        cyc();
        w_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_req_valid", w_req_valid, 0);
        cyc();
        check("rst_mid_id_valid", w_id_valid, 0);
        check("rst_mid_pc", w_addr, 32'hFFFF_FFFC);
        check("rst_mid_instr", w_id_instr, 32'h0);
        rst = 1'b0;
        w_rsp_valid = 1'b1; w_rsp_data = 32'hDEAD_BEEF;
        cyc();
        w_rsp_valid = 1'b0;
        check("late_rsp_ignored", w_id_valid, 0);
        check("late_rsp_req", w_req_valid, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
